// File: rtl/alu_seq.sv
// Registered, parametrised ALU with a start/busy/done handshake.
// Single-cycle ops finish on the accept edge; MUL iterates one shift-add step per cycle.
module alu_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    output logic [WIDTH-1:0] R,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             C,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_SHL = 4'b0100;
    localparam logic [3:0] OP_SHR = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_OR  = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;

    localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state_q;
    logic [WIDTH-1:0]     r_q;
    logic                 z_q, n_q, v_q, c_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   shlWide;
    logic [2*WIDTH-1:0]   shrWide;
    logic [WIDTH-1:0]     res_d;
    logic                 c_d, v_d;
    logic [2*WIDTH-1:0]   acc_d;

    // Shifts go through a double-width window so the last bit shifted out
    // always lands at a fixed position (bit WIDTH for SHL, WIDTH-1 for SHR).
    always_comb begin
        sum     = {1'b0, A} + {1'b0, B};
        diff    = {1'b0, A} + {1'b0, ~B} + (WIDTH + 1)'(1);
        shlWide = {{WIDTH{1'b0}}, A} << B;
        shrWide = {A, {WIDTH{1'b0}}} >> B;
        res_d   = '0;
        c_d     = 1'b0;
        v_d     = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                res_d = sum[WIDTH-1:0];
                c_d   = sum[WIDTH];
                v_d   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                res_d = diff[WIDTH-1:0];
                c_d   = diff[WIDTH];
                v_d   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: res_d = A & B;
            OP_OR:  res_d = A | B;
            OP_XOR: res_d = A ^ B;
            OP_SHL: begin
                if (B == '0) begin
                    res_d = A;
                end else if (B <= WIDTH_V) begin
                    res_d = shlWide[WIDTH-1:0];
                    c_d   = shlWide[WIDTH];
                end
            end
            OP_SHR: begin
                if (B == '0) begin
                    res_d = A;
                end else if (B <= WIDTH_V) begin
                    res_d = shrWide[2*WIDTH-1:WIDTH];
                    c_d   = shrWide[WIDTH-1];
                end
            end
            default: begin
                res_d = '0;
            end
        endcase
    end

    always_comb begin
        acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    end

    // A start seen in DONE is accepted exactly as in IDLE, which allows
    // back-to-back operations.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            r_q      <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            c_q      <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (ALUControl == OP_MUL) begin
                            state_q  <= S_MUL;
                            mcand_q  <= {{WIDTH{1'b0}}, A};
                            mplier_q <= B;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                        end else begin
                            state_q <= S_DONE;
                            r_q     <= res_d;
                            z_q     <= (res_d == '0);
                            n_q     <= res_d[WIDTH-1];
                            v_q     <= v_d;
                            c_q     <= c_d;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_q <= S_DONE;
                        r_q     <= acc_d[WIDTH-1:0];
                        z_q     <= (acc_d[WIDTH-1:0] == '0);
                        n_q     <= acc_d[WIDTH-1];
                        v_q     <= 1'b0;
                        c_q     <= |acc_d[2*WIDTH-1:WIDTH];
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign R    = r_q;
    assign Z    = z_q;
    assign N    = n_q;
    assign V    = v_q;
    assign C    = c_q;
    assign busy = (state_q == S_MUL);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq at WIDTH=4, plus hand-written
// sequences for the ignored-start, back-to-back and reset-abort cases.
module tb_alu_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] ALUControl;
    logic [3:0] R;
    logic       Z, N, V, C, busy, done;

    int compared   = 0;
    int mismatched = 0;

    alu_seq #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .R          (R),
        .Z          (Z),
        .N          (N),
        .V          (V),
        .C          (C),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ctl;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] r;
        logic       z;
        logic       n;
        logic       v;
        logic       c;
        int         lat;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Called just after a falling edge; the op is accepted on the next rising edge.
    task automatic applyStimulus(input logic [3:0] ctl, input logic [3:0] a,
                                 input logic [3:0] b);
        ALUControl = ctl;
        A          = a;
        B          = b;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic waitDone(input string name, input logic expBusy, output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            checkOutput({name, ".busy"}, 32'(busy), 32'(expBusy));
            @(negedge clk);
            lat++;
        end
        checkOutput({name, ".busyAtDone"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int  lat;
        bit  sawDone;
        string nm;

        vecs[0]  = '{4'b0000, 4'b1000, 4'b1010, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 1};
        vecs[1]  = '{4'b0000, 4'b0100, 4'b0011, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[2]  = '{4'b0001, 4'b0011, 4'b0011, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        vecs[3]  = '{4'b0001, 4'b0000, 4'b0001, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[4]  = '{4'b1001, 4'b0011, 4'b0101, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 5};
        vecs[5]  = '{4'b1001, 4'b0110, 4'b0011, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 5};
        vecs[6]  = '{4'b0100, 4'b1010, 4'b0010, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[7]  = '{4'b0101, 4'b1101, 4'b0010, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[8]  = '{4'b0100, 4'b1000, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        vecs[9]  = '{4'b0100, 4'b1111, 4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[10] = '{4'b0110, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[11] = '{4'b0111, 4'b1100, 4'b1010, 4'b1110, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[12] = '{4'b1000, 4'b1100, 4'b1010, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[13] = '{4'b0001, 4'b0111, 4'b1111, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        vecs[14] = '{4'b0101, 4'b1001, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        vecs[15] = '{4'b0100, 4'b0110, 4'b0000, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[16] = '{4'b0010, 4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[17] = '{4'b0000, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        vecs[18] = '{4'b1001, 4'b1111, 4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 5};
        vecs[19] = '{4'b1001, 4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 5};

        reset      = 1'b1;
        start      = 1'b0;
        A          = '0;
        B          = '0;
        ALUControl = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset.R", 32'(R), 32'd0);
        checkOutput("reset.ZNVC", 32'({Z, N, V, C}), 32'd0);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            nm = $sformatf("v%0d", i);
            applyStimulus(vecs[i].ctl, vecs[i].a, vecs[i].b);
            waitDone(nm, vecs[i].lat > 1, lat);
            checkOutput({nm, ".latency"}, 32'(lat), 32'(vecs[i].lat));
            checkOutput({nm, ".R"}, 32'(R), 32'(vecs[i].r));
            checkOutput({nm, ".Z"}, 32'(Z), 32'(vecs[i].z));
            checkOutput({nm, ".N"}, 32'(N), 32'(vecs[i].n));
            checkOutput({nm, ".V"}, 32'(V), 32'(vecs[i].v));
            checkOutput({nm, ".C"}, 32'(C), 32'(vecs[i].c));
            @(negedge clk);
            checkOutput({nm, ".donePulse"}, 32'(done), 32'd0);
            checkOutput({nm, ".Rheld"}, 32'(R), 32'(vecs[i].r));
        end

        // Second start during MUL must be ignored; R holds the ADD result until done.
        applyStimulus(4'b0000, 4'b0100, 4'b0011);
        waitDone("seqA.add", 1'b0, lat);
        @(negedge clk);
        applyStimulus(4'b1001, 4'b0011, 4'b0101);
        ALUControl = 4'b0000;
        A          = 4'b0001;
        B          = 4'b0001;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 2;
        while (done !== 1'b1 && lat < 20) begin
            checkOutput("seqA.holdR", 32'(R), 32'h7);
            @(negedge clk);
            lat++;
        end
        checkOutput("seqA.latency", 32'(lat), 32'd5);
        checkOutput("seqA.R", 32'(R), 32'hF);
        checkOutput("seqA.C", 32'(C), 32'd0);
        sawDone = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) sawDone = 1'b1;
        end
        checkOutput("seqA.noExtraOp", 32'(sawDone), 32'd0);
        checkOutput("seqA.Rfinal", 32'(R), 32'hF);

        // Start issued in the DONE cycle is accepted back-to-back.
        applyStimulus(4'b0000, 4'b0100, 4'b0011);
        waitDone("seqB.add", 1'b0, lat);
        checkOutput("seqB.addDone", 32'(done), 32'd1);
        applyStimulus(4'b1000, 4'b1100, 4'b1010);
        checkOutput("seqB.xorDone", 32'(done), 32'd1);
        checkOutput("seqB.xorR", 32'(R), 32'h6);
        @(negedge clk);
        checkOutput("seqB.idle", 32'(done), 32'd0);

        // Reset during MUL aborts it with no done pulse afterwards.
        applyStimulus(4'b1001, 4'b0011, 4'b0101);
        checkOutput("seqC.busyBefore", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("seqC.busy", 32'(busy), 32'd0);
        checkOutput("seqC.R", 32'(R), 32'd0);
        checkOutput("seqC.ZNVC", 32'({Z, N, V, C}), 32'd0);
        checkOutput("seqC.done", 32'(done), 32'd0);
        sawDone = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) sawDone = 1'b1;
        end
        checkOutput("seqC.noDone", 32'(sawDone), 32'd0);
        checkOutput("seqC.Rheld", 32'(R), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
